sipo_deframer: RTL

Downstream receive stage for the 12-bit LSB-first serial stream produced by our parallel-to-serial shifter. Samples one bit per qualified clock, aligns words on a frame_start marker, and assembles each WIDTH-bit word. Presents completed words through a one-deep valid/ready output buffer and flags words lost to back-pressure.

---
 rtl/sipo_deframer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/sipo_deframer.sv
// Serial-to-parallel deframer: aligns LSB-first words on frame_start and hands them out through a one-deep valid/ready buffer.
// Optional even-parity bit after each word when SIPO_DEFRAMER_PARITY_EN is defined.
module sipo_deframer #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             serial_in,
    input  logic             bit_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             overrun,
    input  logic             overrun_clr,
    output logic             busy,
    output logic             parity_err
);

    localparam int CW = $clog2(WIDTH + 1);

`ifdef SIPO_DEFRAMER_PARITY_EN
    typedef enum logic [1:0] {IDLE, RECV, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, RECV} state_t;
`endif

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_next;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_next;
    logic [WIDTH-1:0] w_sampled;
    logic [WIDTH-1:0] w_word;
    logic             w_complete;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_overrun;
`ifdef SIPO_DEFRAMER_PARITY_EN
    logic             w_perr;
    logic             r_perr;
`endif

    // New bits enter at the top so the first bit ends up in bit 0.
    assign w_sampled = {serial_in, r_shift[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_shift <= w_shift_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_shift_next = r_shift;
        w_word       = w_sampled;
        w_complete   = 1'b0;
`ifdef SIPO_DEFRAMER_PARITY_EN
        w_perr       = 1'b0;
`endif
        if (bit_valid) begin
            if (frame_start) begin
                // Marker always restarts alignment, silently discarding any partial word.
                w_state_next = RECV;
                w_cnt_next   = CW'(1);
                w_shift_next = w_sampled;
            end else begin
                case (r_state)
                    RECV: begin
                        w_shift_next = w_sampled;
                        if (r_cnt == CW'(WIDTH - 1)) begin
`ifdef SIPO_DEFRAMER_PARITY_EN
                            w_state_next = PARITY;
                            w_cnt_next   = CW'(WIDTH);
`else
                            w_state_next = IDLE;
                            w_cnt_next   = '0;
                            w_complete   = 1'b1;
`endif
                        end else begin
                            w_cnt_next = r_cnt + CW'(1);
                        end
                    end
`ifdef SIPO_DEFRAMER_PARITY_EN
                    PARITY: begin
                        w_state_next = IDLE;
                        w_cnt_next   = '0;
                        w_complete   = 1'b1;
                        w_word       = r_shift;
                        w_perr       = (^r_shift) ^ serial_in;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
`ifdef SIPO_DEFRAMER_PARITY_EN
            r_perr    <= 1'b0;
`endif
        end else begin
            if (w_complete && (!r_valid || data_ready)) begin
                r_data  <= w_word;
                r_valid <= 1'b1;
`ifdef SIPO_DEFRAMER_PARITY_EN
                r_perr  <= w_perr;
`endif
            end else if (r_valid && data_ready) begin
                r_valid <= 1'b0;
            end
            // A drop in the same cycle as a clear request wins.
            if (w_complete && r_valid && !data_ready) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign overrun    = r_overrun;
    assign busy       = (r_state != IDLE);
`ifdef SIPO_DEFRAMER_PARITY_EN
    assign parity_err = r_perr;
`else
    assign parity_err = 1'b0;
`endif

endmodule
